// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (imem) and MEM-stage (dmem) ports.
// Optional imem fairness is built only when YARC_ARB_FAIRNESS_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned DMEM_BURST_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        imem_req_i,
  input  logic [31:0] imem_addr_i,
  output logic        imem_gnt_o,
  output logic        imem_rvalid_o,
  output logic [31:0] imem_rdata_o,
  input  logic        dmem_req_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [3:0]  dmem_wsel_byte_i,
  input  logic [31:0] dmem_wdata_i,
  output logic        dmem_gnt_o,
  output logic        dmem_rvalid_o,
  output logic [31:0] dmem_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wsel_byte_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  // state  | meaning
  // S_IDLE | no access outstanding; winner drives the memory request
  // S_WAIT | one access granted, waiting for mem_rvalid_i
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t state, state_nxt;
  logic   owner_dmem;
  logic   err_q;
  logic   imem_first;
  logic   pick_dmem;
  logic   any_req;
  logic   grant;

`ifdef YARC_ARB_FAIRNESS_EN
  localparam logic [2:0] BURST_MAX = 3'(DMEM_BURST_MAX);
  logic [2:0] burst_cnt;

  assign imem_first = imem_req_i && (burst_cnt == BURST_MAX);

  // Counts dmem grants that overtook a waiting imem request.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                          burst_cnt <= '0;
    else if (!imem_req_i || imem_gnt_o)   burst_cnt <= '0;
    else if (dmem_gnt_o && burst_cnt != 3'd7) burst_cnt <= burst_cnt + 3'd1;
  end
`else
  logic unused_burst_max;
  assign unused_burst_max = (DMEM_BURST_MAX != 0);
  assign imem_first       = 1'b0;
`endif

  assign any_req   = imem_req_i || dmem_req_i;
  assign pick_dmem = dmem_req_i && !imem_first;
  assign grant     = (state == S_IDLE) && any_req && mem_gnt_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (grant)        state_nxt = S_WAIT;
      S_WAIT: if (mem_rvalid_i) state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o       = 1'b0;
    mem_addr_o      = imem_addr_i;
    mem_wsel_byte_o = 4'b0000;
    mem_wdata_o     = '0;
    imem_gnt_o      = 1'b0;
    dmem_gnt_o      = 1'b0;
    imem_rvalid_o   = 1'b0;
    dmem_rvalid_o   = 1'b0;
    busy_o          = 1'b0;
    if (rstn_i) begin
      unique case (state)
        S_IDLE: begin
          mem_req_o = any_req;
          if (pick_dmem) begin
            mem_addr_o      = dmem_addr_i;
            mem_wsel_byte_o = dmem_wsel_byte_i;
            mem_wdata_o     = dmem_wdata_i;
          end
          imem_gnt_o = grant && !pick_dmem;
          dmem_gnt_o = grant && pick_dmem;
        end
        S_WAIT: begin
          busy_o        = 1'b1;
          imem_rvalid_o = mem_rvalid_i && !owner_dmem;
          dmem_rvalid_o = mem_rvalid_i && owner_dmem;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_dmem <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (grant) owner_dmem <= pick_dmem;
      // A response with nothing outstanding means the memory side lost sync.
      if (state == S_IDLE && mem_rvalid_i) err_q <= 1'b1;
    end
  end

  assign err_o        = err_q;
  assign imem_rdata_o = mem_rdata_i;
  assign dmem_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then randomized traffic against a
// transaction-level model (outstanding owner, error flag, dmem streak count).
module tb_mem_port_arbiter;

`ifdef YARC_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wsel;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wsel;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy, err;

  int checks = 0;
  int errors = 0;

  // Model: who holds the outstanding access (0 none, 1 imem, 2 dmem).
  int owner = 0;
  bit m_err = 1'b0;
  int streak = 0;
  bit last_gi, last_gd;
  int imem_grants;

  mem_port_arbiter #(.DMEM_BURST_MAX(BURST)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .imem_req_i(imem_req), .imem_addr_i(imem_addr), .imem_gnt_o(imem_gnt),
    .imem_rvalid_o(imem_rvalid), .imem_rdata_o(imem_rdata),
    .dmem_req_i(dmem_req), .dmem_addr_i(dmem_addr), .dmem_wsel_byte_i(dmem_wsel),
    .dmem_wdata_i(dmem_wdata), .dmem_gnt_o(dmem_gnt), .dmem_rvalid_o(dmem_rvalid),
    .dmem_rdata_o(dmem_rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_wsel_byte_o(mem_wsel),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle and advances the model.
  task automatic cycle();
    int  win;
    bit  gi, gd, ri, rd;
    #4;
    win = 0; gi = 0; gd = 0; ri = 0; rd = 0;
    if (owner == 0) begin
      if (FAIR && imem_req && streak >= BURST) win = 1;
      else if (dmem_req)                      win = 2;
      else if (imem_req)                      win = 1;
      gi = mem_gnt && (win == 1);
      gd = mem_gnt && (win == 2);
    end else begin
      ri = mem_rvalid && (owner == 1);
      rd = mem_rvalid && (owner == 2);
    end
    chk("mem_req",     32'(mem_req),     32'(win != 0));
    chk("imem_gnt",    32'(imem_gnt),    32'(gi));
    chk("dmem_gnt",    32'(dmem_gnt),    32'(gd));
    chk("imem_rvalid", 32'(imem_rvalid), 32'(ri));
    chk("dmem_rvalid", 32'(dmem_rvalid), 32'(rd));
    chk("busy",        32'(busy),        32'(owner != 0));
    chk("err",         32'(err),         32'(m_err));
    if (win == 2) begin
      chk("mem_addr_d", mem_addr, dmem_addr);
      chk("mem_wsel_d", 32'(mem_wsel), 32'(dmem_wsel));
      chk("mem_wdata_d", mem_wdata, dmem_wdata);
    end else if (win == 1) begin
      chk("mem_addr_i", mem_addr, imem_addr);
      chk("mem_wsel_i", 32'(mem_wsel), 32'd0);
    end
    if (ri) chk("imem_rdata", imem_rdata, mem_rdata);
    if (rd) chk("dmem_rdata", dmem_rdata, mem_rdata);
    if (owner == 0) begin
      if (mem_rvalid) m_err = 1'b1;
      if (gi) owner = 1;
      if (gd) owner = 2;
    end else if (mem_rvalid) owner = 0;
    if (!imem_req || gi) streak = 0;
    else if (gd && streak < 7) streak++;
    if (gi) imem_grants++;
    last_gi = gi;
    last_gd = gd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req = 0; dmem_req = 0; mem_gnt = 0; mem_rvalid = 0;
    dmem_wsel = 4'b0000; dmem_wdata = '0;
  endtask

  initial begin
    rstn = 1'b0;
    imem_addr = 32'h0; dmem_addr = 32'h0; mem_rdata = 32'h0;
    idle_inputs();
    // Outputs must stay quiet under reset even with everything asserted.
    #2;
    imem_req = 1; dmem_req = 1; mem_gnt = 1; mem_rvalid = 1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_imem_gnt", 32'(imem_gnt), 32'd0);
    chk("rst_dmem_gnt", 32'(dmem_gnt), 32'd0);
    chk("rst_rvalid", 32'({imem_rvalid, dmem_rvalid}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    @(posedge clk); #1;

    // imem-only read with one-cycle memory latency
    imem_req = 1; imem_addr = 32'h100; mem_gnt = 1;
    cycle();
    chk("d1_gnt", 32'(last_gi), 32'd1);
    imem_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    cycle();
    chk("d1_rdata", imem_rdata, 32'hDEADBEEF);
    mem_rvalid = 0;

    // simultaneous requests: dmem write first, imem after the ack bubble
    imem_req = 1; imem_addr = 32'h104;
    dmem_req = 1; dmem_addr = 32'h200; dmem_wsel = 4'b0011; dmem_wdata = 32'h12345678;
    mem_gnt = 1;
    cycle();
    chk("d2_dmem_first", 32'(last_gd), 32'd1);
    dmem_req = 0; dmem_wsel = 0; mem_rvalid = 1; mem_rdata = 32'h0;
    cycle();
    mem_rvalid = 0;
    cycle();
    chk("d2_imem_next", 32'(last_gi), 32'd1);
    imem_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE0001;
    cycle();
    mem_rvalid = 0;

    // memory stalls the grant for three cycles
    dmem_req = 1; dmem_addr = 32'h300; dmem_wsel = 0; mem_gnt = 0;
    repeat (3) cycle();
    mem_gnt = 1;
    cycle();
    chk("d3_gnt4", 32'(last_gd), 32'd1);
    dmem_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000BEEF;
    cycle();
    mem_rvalid = 0;

    // spurious response in IDLE
    mem_rvalid = 1;
    cycle();
    mem_rvalid = 0;
    repeat (2) cycle();
    chk("d4_err_sticky", 32'(err), 32'd1);

    // reset in the middle of an access
    imem_req = 1; imem_addr = 32'h400; mem_gnt = 1;
    cycle();
    idle_inputs();
    rstn = 1'b0;
    #1;
    chk("d5_busy_rst", 32'(busy), 32'd0);
    chk("d5_err_rst", 32'(err), 32'd0);
    owner = 0; m_err = 0; streak = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    imem_req = 1; imem_addr = 32'h404; mem_gnt = 1;
    cycle();
    chk("d5_regrant", 32'(last_gi), 32'd1);
    imem_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
    cycle();
    mem_rvalid = 0;

    // both ports saturating, memory always ready
    imem_grants = 0;
    imem_req = 1; imem_addr = 32'h500; dmem_req = 1; dmem_addr = 32'h600; mem_gnt = 1;
    for (int i = 0; i < 30; i++) begin
      mem_rvalid = (owner != 0);
      mem_rdata = $urandom;
      cycle();
    end
    if (FAIR) chk("d6_imem_served", 32'(imem_grants), 32'd3);
    else      chk("d6_imem_starved", 32'(imem_grants), 32'd0);
    idle_inputs();
    mem_rvalid = (owner != 0);
    cycle();
    mem_rvalid = 0;

    // randomized traffic; requesters hold req and payload until granted
    last_gi = 1; last_gd = 1;
    for (int i = 0; i < 600; i++) begin
      if (!imem_req || last_gi) begin
        imem_req = ($urandom_range(0, 2) != 0);
        imem_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dmem_req || last_gd) begin
        dmem_req = ($urandom_range(0, 2) != 0);
        dmem_addr = $urandom;
        dmem_wsel = 4'($urandom);
        dmem_wdata = $urandom;
      end
      mem_gnt = ($urandom_range(0, 3) != 0);
      mem_rvalid = (owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      mem_rdata = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
